// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
//   SPI target (slave) for an SPI bus that is oversampled by the system clock.
//   SCLK, CS_n and MOSI are synchronised into i_clock, and the block detects
//   their edges in the i_clock domain. Words are shifted MSB first in all four
//   CPOL/CPHA modes. A single-entry holding register, written through a
//   valid/ready handshake, feeds the transmit shifter.
//
// Ports
//   i_clock, i_reset_n      system clock (>= 4x SCLK), async active-low reset
//   i_clock_polarity/phase  CPOL/CPHA, latched when a frame starts
//   i_tx_data/i_tx_valid    write into the TX holding register
//   o_tx_ready              holding register is empty
//   o_rx_data/o_rx_valid    last complete received word, one-cycle valid pulse
//   o_busy                  synchronised CS is asserted (frame active)
//   o_tx_underrun           one-cycle pulse: a word started with empty holding
//   o_frame_error           one-cycle pulse: CS released mid-word
//   i_spi_cs_n/clock/mosi   asynchronous SPI pins
//   o_spi_miso/o_spi_miso_oe  MISO data and pad output enable
// ---------------------------------------------------------------------------
module spi_slave #(
    parameter int SPI_DATA_WIDTH = 8,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_clock_polarity,
    input  logic                      i_clock_phase,
    input  logic [SPI_DATA_WIDTH-1:0] i_tx_data,
    input  logic                      i_tx_valid,
    output logic                      o_tx_ready,
    output logic [SPI_DATA_WIDTH-1:0] o_rx_data,
    output logic                      o_rx_valid,
    output logic                      o_busy,
    output logic                      o_tx_underrun,
    output logic                      o_frame_error,
    input  logic                      i_spi_cs_n,
    input  logic                      i_spi_clock,
    input  logic                      i_spi_mosi,
    output logic                      o_spi_miso,
    output logic                      o_spi_miso_oe
);

    localparam int N     = SPI_DATA_WIDTH;
    localparam int CNT_W = $clog2(N);

    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

    // ------------------------------------------------------------------
    // Input synchronisers plus one extra flop for edge detection.
    // CS resets to "low" so that a CS already low at reset release shows
    // no falling edge and therefore does not start a frame.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_mosi_sync;
    logic                   r_cs_prev, r_sclk_prev;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cs_sync   <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_prev   <= 1'b0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   i_spi_cs_n};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_clock};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    logic w_cs, w_sclk, w_mosi;
    logic w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;

    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_fall   = ~w_cs &  r_cs_prev;
    assign w_cs_rise   =  w_cs & ~r_cs_prev;
    assign w_sclk_rise =  w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk &  r_sclk_prev;

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    state_t r_state, w_state_next;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_cs_fall) w_state_next = S_ACTIVE;
            S_ACTIVE: if (w_cs_rise) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy        = (r_state == S_ACTIVE);
        o_spi_miso_oe = (r_state == S_ACTIVE);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic             r_cpol, r_cpha;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_load_pend;   // next shift event is a word-boundary load
    logic [N-1:0]     r_rx_shift, r_rx_data, r_tx_shift, r_hold;
    logic             r_rx_valid, r_frame_error, r_tx_underrun, r_tx_ready;

    logic         w_lead, w_trail, w_run, w_start, w_stop;
    logic         w_sample, w_shift, w_load, w_last, w_wr;
    logic [N-1:0] w_rx_next;

    // Leading edge leaves the CPOL idle level, trailing edge returns to it.
    assign w_lead    = r_cpol ? w_sclk_fall : w_sclk_rise;
    assign w_trail   = r_cpol ? w_sclk_rise : w_sclk_fall;
    // An SCLK edge that coincides with CS release belongs to no word.
    assign w_run     = (r_state == S_ACTIVE) && !w_cs_rise;
    assign w_start   = (r_state == S_IDLE) && w_cs_fall;
    assign w_stop    = (r_state == S_ACTIVE) && w_cs_rise;
    assign w_sample  = w_run && (r_cpha ? w_trail : w_lead);
    assign w_shift   = w_run && (r_cpha ? w_lead : w_trail);
    // CPHA=0 must present the MSB before the first leading edge, so it loads
    // at frame start; CPHA=1 loads on the first leading edge instead.
    assign w_load    = (w_start && !i_clock_phase) || (w_shift && r_load_pend);
    assign w_last    = (r_bit_cnt == CNT_W'(N-1));
    assign w_wr      = i_tx_valid && r_tx_ready;
    assign w_rx_next = {r_rx_shift[N-2:0], w_mosi};

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cpol        <= 1'b0;
            r_cpha        <= 1'b0;
            r_bit_cnt     <= '0;
            r_load_pend   <= 1'b0;
            r_rx_shift    <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
            r_tx_shift    <= '0;
            r_hold        <= '0;
            r_tx_ready    <= 1'b1;
            r_tx_underrun <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
            r_tx_underrun <= 1'b0;

            if (w_start) begin
                r_cpol      <= i_clock_polarity;
                r_cpha      <= i_clock_phase;
                r_bit_cnt   <= '0;
                r_load_pend <= i_clock_phase;
            end

            if (w_stop) begin
                if (r_bit_cnt != '0) r_frame_error <= 1'b1;
                r_bit_cnt   <= '0;
                r_rx_shift  <= '0;   // partial word is discarded
                r_load_pend <= 1'b0;
            end

            if (w_sample) begin
                r_rx_shift <= w_rx_next;
                if (w_last) begin
                    r_rx_data   <= w_rx_next;
                    r_rx_valid  <= 1'b1;
                    r_bit_cnt   <= '0;
                    r_load_pend <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            // Load and sample fall on opposite SCLK edges, so the pending
            // flag is never set and cleared in the same cycle.
            if (w_load) begin
                r_tx_shift    <= r_tx_ready ? '0 : r_hold;
                r_tx_underrun <= r_tx_ready;
                r_tx_ready    <= 1'b1;
                r_load_pend   <= 1'b0;
            end else if (w_shift) begin
                r_tx_shift <= {r_tx_shift[N-2:0], 1'b0};
            end

            // A write only happens while empty; a coincident load has already
            // taken zeros, so the written word stays in holding (no bypass).
            if (w_wr) begin
                r_hold     <= i_tx_data;
                r_tx_ready <= 1'b0;
            end
        end
    end

    assign o_tx_ready    = r_tx_ready;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_tx_underrun = r_tx_underrun;
    assign o_frame_error = r_frame_error;
    assign o_spi_miso    = r_tx_shift[N-1];

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_clock_polarity, i_clock_phase;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic [7:0] o_rx_data;
    logic       o_rx_valid, o_busy, o_tx_underrun, o_frame_error;
    logic       i_spi_cs_n, i_spi_clock, i_spi_mosi;
    logic       o_spi_miso, o_spi_miso_oe;

    spi_slave #(.SPI_DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_clock_polarity (i_clock_polarity),
        .i_clock_phase    (i_clock_phase),
        .i_tx_data        (i_tx_data),
        .i_tx_valid       (i_tx_valid),
        .o_tx_ready       (o_tx_ready),
        .o_rx_data        (o_rx_data),
        .o_rx_valid       (o_rx_valid),
        .o_busy           (o_busy),
        .o_tx_underrun    (o_tx_underrun),
        .o_frame_error    (o_frame_error),
        .i_spi_cs_n       (i_spi_cs_n),
        .i_spi_clock      (i_spi_clock),
        .i_spi_mosi       (i_spi_mosi),
        .o_spi_miso       (o_spi_miso),
        .o_spi_miso_oe    (o_spi_miso_oe)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         un_cnt = 0;
    int         fe_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every received word must match the next expected word.
    always @(negedge clk) begin
        if (rst_n && o_rx_valid) begin
            if (exp_q.size() == 0) chk("rx_spurious", 32'(o_rx_valid), 32'd0);
            else                   chk("rx_data", 32'(o_rx_data), 32'(exp_q.pop_front()));
        end
        if (o_tx_underrun) un_cnt++;
        if (o_frame_error) fe_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_write(input logic [7:0] d);
        int t = 0;
        while (!o_tx_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        chk("hold_ready", 32'(o_tx_ready), 32'd1);
        i_tx_data  = d;
        i_tx_valid = 1'b1;
        @(negedge clk);
        i_tx_valid = 1'b0;
    endtask

    task automatic cs_start(input bit cpol, input bit cpha);
        i_clock_polarity = cpol;
        i_clock_phase    = cpha;
        i_spi_clock      = cpol;
        wait_clk(6);
        i_spi_cs_n = 1'b0;
        wait_clk(5);
        chk("busy_on", 32'(o_busy), 32'd1);
        chk("oe_on", 32'(o_spi_miso_oe), 32'd1);
        // Mode inputs are latched at frame start; scramble them mid-frame.
        i_clock_polarity = 1'($urandom_range(1, 0));
        i_clock_phase    = 1'($urandom_range(1, 0));
    endtask

    // One SCLK period of 8 system clocks; MISO is checked when the master
    // would sample it.
    task automatic xfer_bit(input bit cpol, input bit cpha, input bit mosi_b, input bit exp_miso);
        if (!cpha) begin
            i_spi_mosi = mosi_b;
            wait_clk(2);
            chk("miso", 32'(o_spi_miso), 32'(exp_miso));
            i_spi_clock = ~cpol;
            wait_clk(4);
            i_spi_clock = cpol;
            wait_clk(2);
        end else begin
            i_spi_clock = ~cpol;
            i_spi_mosi  = mosi_b;
            wait_clk(4);
            chk("miso", 32'(o_spi_miso), 32'(exp_miso));
            i_spi_clock = cpol;
            wait_clk(4);
        end
    endtask

    task automatic cs_end();
        wait_clk(2);
        i_spi_cs_n = 1'b1;
        wait_clk(6);
        chk("busy_off", 32'(o_busy), 32'd0);
        chk("oe_off", 32'(o_spi_miso_oe), 32'd0);
    endtask

    // Reference model: a word is loaded at frame start (CPHA=0) or the first
    // leading edge (CPHA=1), and again on the first shift edge after every
    // completed word. Load 0 gets the preload, load 1 the refill, else zeros
    // with an underrun.
    task automatic run_frame(input bit cpol, input bit cpha, input int nbits,
                             input logic [15:0] mosi, input bit pre, input logic [7:0] pre_w,
                             input bit refill, input logic [7:0] ref_w);
        logic [7:0] ld[3];
        int nloads, exp_un, u0, f0;
        nloads = cpha ? (nbits + 7) / 8 : 1 + nbits / 8;
        exp_un = 0;
        for (int j = 0; j < 3; j++) begin
            bit have;
            have  = (j == 0 && pre) || (j == 1 && refill);
            ld[j] = (j == 0 && pre) ? pre_w : ((j == 1 && refill) ? ref_w : 8'h00);
            if (j < nloads && !have) exp_un++;
        end
        for (int k = 0; k < nbits / 8; k++) exp_q.push_back(mosi[15 - 8 * k -: 8]);
        u0 = un_cnt;
        f0 = fe_cnt;
        chk("ready_idle", 32'(o_tx_ready), 32'd1);
        if (pre) hold_write(pre_w);
        cs_start(cpol, cpha);
        for (int i = 0; i < nbits; i++) begin
            logic [7:0] w;
            w = ld[i / 8];
            xfer_bit(cpol, cpha, mosi[15 - i], w[7 - (i % 8)]);
            if (i == 0 && refill) hold_write(ref_w);
        end
        cs_end();
        chk("underruns", 32'(un_cnt - u0), 32'(exp_un));
        chk("frame_err", 32'(fe_cnt - f0), 32'(nbits % 8 != 0));
        chk("rx_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0, f0;
        rst_n            = 1'b0;
        i_clock_polarity = 1'b0;
        i_clock_phase    = 1'b0;
        i_tx_data        = 8'h00;
        i_tx_valid       = 1'b0;
        i_spi_cs_n       = 1'b1;
        i_spi_clock      = 1'b0;
        i_spi_mosi       = 1'b0;
        wait_clk(3);
        chk("rst_ready", 32'(o_tx_ready), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_rx_data", 32'(o_rx_data), 32'd0);
        chk("rst_rx_valid", 32'(o_rx_valid), 32'd0);
        chk("rst_oe", 32'(o_spi_miso_oe), 32'd0);
        chk("rst_miso", 32'(o_spi_miso), 32'd0);
        rst_n = 1'b1;
        wait_clk(6);

        // All four modes, 0xA5 out / 0x3C in
        for (int m = 0; m < 4; m++)
            run_frame(1'(m >> 1), 1'(m & 1), 8, 16'h3C00, 1'b1, 8'hA5, 1'b0, 8'h00);

        // Back-to-back words with refill after the first load
        run_frame(1'b0, 1'b0, 16, 16'h1234, 1'b1, 8'hA5, 1'b1, 8'h81);
        run_frame(1'b1, 1'b1, 16, 16'h1234, 1'b1, 8'hA5, 1'b1, 8'h81);

        // Underrun: no preload
        run_frame(1'b0, 1'b1, 8, 16'hFF00, 1'b0, 8'h00, 1'b0, 8'h00);

        // Abort after 5 bits, then a clean frame
        run_frame(1'b0, 1'b0, 5, 16'hB000, 1'b1, 8'h66, 1'b0, 8'h00);
        run_frame(1'b0, 1'b1, 5, 16'hB000, 1'b0, 8'h00, 1'b0, 8'h00);
        run_frame(1'b0, 1'b0, 8, 16'h5A00, 1'b1, 8'h99, 1'b0, 8'h00);

        // Reset mid-frame after 3 bits with CS held low
        chk("ready_pre_rst", 32'(o_tx_ready), 32'd1);
        hold_write(8'h77);
        u0 = un_cnt;
        f0 = fe_cnt;
        cs_start(1'b0, 1'b0);
        xfer_bit(1'b0, 1'b0, 1'b1, 1'b0);
        xfer_bit(1'b0, 1'b0, 1'b0, 1'b1);
        xfer_bit(1'b0, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        wait_clk(2);
        chk("midrst_ready", 32'(o_tx_ready), 32'd1);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_oe", 32'(o_spi_miso_oe), 32'd0);
        rst_n = 1'b1;
        wait_clk(10);
        chk("cs_low_no_start", 32'(o_busy), 32'd0);
        i_spi_cs_n = 1'b1;
        wait_clk(6);
        chk("midrst_underrun", 32'(un_cnt - u0), 32'd0);
        chk("midrst_frame_err", 32'(fe_cnt - f0), 32'd0);
        run_frame(1'b0, 1'b0, 8, 16'hC300, 1'b1, 8'h3E, 1'b0, 8'h00);

        // Randomised frames
        for (int r = 0; r < 12; r++) begin
            bit   cpol, cpha, pre, refill;
            int   nbits;
            cpol   = 1'($urandom_range(1, 0));
            cpha   = 1'($urandom_range(1, 0));
            nbits  = ($urandom_range(1, 0) != 0) ? 16 : 8;
            pre    = 1'($urandom_range(1, 0));
            refill = (nbits == 16) && ($urandom_range(1, 0) != 0);
            run_frame(cpol, cpha, nbits, 16'($urandom), pre, 8'($urandom),
                      refill, 8'($urandom));
        end

        wait_clk(10);
        chk("rx_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI target (slave) that pairs with the team's SPI master on the same system-clock-oversampled bus. It synchronises SCLK, CS_n and MOSI into i_clock and detects edges. It shifts MOSI into a receive register and MISO out of a transmit register, MSB first, in all four CPOL/CPHA modes. A single-entry TX holding register with a valid/ready handshake feeds the transmitter; each received word is presented with a one-cycle valid pulse.

Parameters:
SPI_DATA_WIDTH, 8, bits per word (≥2)
SYNC_STAGES, 2, flops per input synchroniser (≥2)

Ports:
i_clock  in  1  system clock; must be ≥4× SCLK frequency
i_reset_n  in  1  reset, asynchronous, active-low
i_clock_polarity  in  1  CPOL (idle SCLK level); sampled at frame start
i_clock_phase  in  1  CPHA; sampled at frame start
i_tx_data  in  SPI_DATA_WIDTH  next word to transmit
i_tx_valid  in  1  i_tx_data valid
o_tx_ready  out  1  holding register empty
o_rx_data  out  SPI_DATA_WIDTH  last complete received word
o_rx_valid  out  1  one-cycle pulse, o_rx_data updated
o_busy  out  1  synchronised CS asserted
o_tx_underrun  out  1  one-cycle pulse, word started with empty holding register
o_frame_error  out  1  one-cycle pulse, CS deasserted mid-word
i_spi_cs_n  in  1  chip select, active-low, asynchronous
i_spi_clock  in  1  SCLK, asynchronous
i_spi_mosi  in  1  MOSI, asynchronous
o_spi_miso  out  1  MISO data
o_spi_miso_oe  out  1  MISO output enable (tristate control at pad)

Behaviour:
- Reset (async assert, sync release): all outputs 0 except o_tx_ready=1; holding empty; state IDLE; bit counter 0; shift registers 0.
- Inputs pass through SYNC_STAGES flops. One more flop gives the previous value for edge detection. Edge flags are combinational on synced and previous values.
- Leading edge = SCLK leaving the CPOL idle level; trailing edge = returning to it.
- CPHA=0: sample MOSI on leading edge, shift MISO on trailing edge. CPHA=1: shift on leading edge, sample on trailing edge.
- FSM IDLE→ACTIVE on synced CS falling edge. In that cycle: latch CPOL/CPHA, bit counter=0.
  - CPHA=0: load TX shift register from holding in the same cycle.
  - CPHA=1: load at the first leading edge.
- ACTIVE→IDLE on synced CS rising edge. If bit counter ≠0, pulse o_frame_error and discard the partial RX word. SCLK edges in IDLE are ignored.
- Sample event: rx_shift <= {rx_shift[N-2:0], mosi_sync}; counter+1. When counter reaches N: o_rx_data <= assembled word, o_rx_valid=1 for exactly one cycle (no backpressure), counter wraps to 0.
- Word-boundary load: first shift event after a wrap (or frame start as above). Load holding→shift register and clear holding. If holding is empty, load all-zeros and pulse o_tx_underrun. Other shift events: shift left, MSB to MISO.
- CS held low across >N bits gives back-to-back words with the same rules.
- o_spi_miso = TX shift MSB. o_spi_miso_oe = 1 in ACTIVE, else 0. o_busy = (state==ACTIVE).
- Holding register: a write occurs on i_tx_valid && o_tx_ready. o_tx_ready = holding empty, registered; it falls the cycle after a write and rises the cycle after a load.
- If a write and a load coincide while holding is empty, there is no bypass: the shift register gets zeros plus underrun, and the written data stays in holding.
- Mid-frame CPOL/CPHA changes have no effect until the next frame.
- Async reset mid-frame: immediate return to reset values. Resynchronise at the next CS falling edge; an already-low CS does not start a frame.

Test Plan:
- Mode 0, N=8: preload 0xA5, master sends 0x3C at SCLK=clk/8 → o_rx_data=0x3C with one o_rx_valid pulse; MISO bits 1,0,1,0,0,1,0,1.
- Modes 1/2/3: same 0xA5/0x3C exchange → identical results; no spurious valid or extra bits.
- Back-to-back: CS low for 16 bits; holding refilled with 0x81 after the first load; master sends 0x12,0x34 → rx 0x12 then 0x34; MISO 0xA5 then 0x81.
- Underrun: no preload, master sends 0xFF → MISO all 0, one o_tx_underrun pulse, rx 0xFF valid.
- Abort: CS released after 5 bits → o_frame_error pulse, no o_rx_valid. Next full frame with 0x5A → rx 0x5A.
- Reset mid-frame after 3 bits with CS held low: no valid. After CS high/low, a full frame with 0xC3 → rx 0xC3, o_tx_ready=1 after reset.
